// File: rtl/contador_sync_monitor.sv
// contador_sync_monitor
//   Receive-side checker for the 3-bit synchronous sequence counter
//   (codes 001->111->000->010->011->001, labels 1,7,8,10,11).
//   Decodes each sample to an index and decimal label, locks after LOCK_LEN
//   consecutive correct transitions and flags every deviation once locked.
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   sample_en    in   q_in valid this cycle
//   q_in         in   counter code {Q2,Q1,Q0}
//   dec_value    out  decimal label of last sample (4'hF if invalid)
//   seq_idx      out  sequence position 0..4 of last sample (7 if invalid)
//   locked       out  sequence tracked and verified
//   err          out  one-cycle pulse, deviation while locked
//   invalid_code out  one-cycle pulse, code 100/101/110 sampled
//   err_count    out  saturating count of err pulses
module contador_sync_monitor #(
   parameter int unsigned LOCK_LEN = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [2:0]       q_in,
   output logic [3:0]       dec_value,
   output logic [2:0]       seq_idx,
   output logic             locked,
   output logic             err,
   output logic             invalid_code,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned MW = $clog2(LOCK_LEN + 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic [MW-1:0]    match_q, match_d;
   logic [3:0]       dec_q, dec_d;
   logic [2:0]       idx_q, idx_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic             inv_q, inv_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             code_valid;
   logic [3:0]       code_dec;
   logic [2:0]       code_idx;
   logic [2:0]       next_code;
   logic             is_next;
   logic [MW-1:0]    match_inc;

   // Decode of the incoming sample
   always_comb begin
      code_valid = 1'b1;
      code_dec   = 4'hF;
      code_idx   = 3'd7;
      case (q_in)
         3'b001:  begin code_dec = 4'd1;  code_idx = 3'd0; end
         3'b111:  begin code_dec = 4'd7;  code_idx = 3'd1; end
         3'b000:  begin code_dec = 4'd8;  code_idx = 3'd2; end
         3'b010:  begin code_dec = 4'd10; code_idx = 3'd3; end
         3'b011:  begin code_dec = 4'd11; code_idx = 3'd4; end
         default: code_valid = 1'b0;
      endcase
   end

   // Expected successor of the last valid code
   always_comb begin
      case (prev_q)
         3'b001:  next_code = 3'b111;
         3'b111:  next_code = 3'b000;
         3'b000:  next_code = 3'b010;
         3'b010:  next_code = 3'b011;
         default: next_code = 3'b001;
      endcase
   end

   // A repeated code never equals its successor, so it counts as wrong here
   assign is_next   = code_valid && (q_in == next_code);
   assign match_inc = match_q + MW'(1);

   // State register and all output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SEARCH;
         prev_q   <= 3'b000;
         match_q  <= '0;
         dec_q    <= 4'd0;
         idx_q    <= 3'd7;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         inv_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         match_q  <= match_d;
         dec_q    <= dec_d;
         idx_q    <= idx_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         inv_q    <= inv_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state logic: tracking state, last valid code and run length
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      match_d = match_q;
      if (sample_en) begin
         case (state_q)
            ST_SEARCH: begin
               if (code_valid) begin
                  prev_d  = q_in;
                  match_d = '0;
                  state_d = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (!code_valid) begin
                  state_d = ST_SEARCH;
               end else if (is_next) begin
                  prev_d  = q_in;
                  match_d = match_inc;
                  if (match_inc == MW'(LOCK_LEN)) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  prev_d  = q_in;
                  match_d = '0;
               end
            end
            ST_LOCKED: begin
               if (!code_valid) begin
                  state_d = ST_SEARCH;
               end else if (is_next) begin
                  prev_d = q_in;
               end else begin
                  prev_d  = q_in;
                  match_d = '0;
                  state_d = ST_TRACK;
               end
            end
            default: begin
               state_d = ST_SEARCH;
               match_d = '0;
            end
         endcase
      end
   end

   // Output logic: decode, lock flag, pulses and saturating error count
   always_comb begin
      dec_d    = dec_q;
      idx_d    = idx_q;
      locked_d = (state_d == ST_LOCKED);
      err_d    = 1'b0;
      inv_d    = 1'b0;
      cnt_d    = cnt_q;
      if (sample_en) begin
         dec_d = code_dec;
         idx_d = code_idx;
         inv_d = !code_valid;
         if (state_q == ST_LOCKED && !is_next) begin
            err_d = 1'b1;
            if (!(&cnt_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign dec_value    = dec_q;
   assign seq_idx      = idx_q;
   assign locked       = locked_q;
   assign err          = err_q;
   assign invalid_code = inv_q;
   assign err_count    = cnt_q;

endmodule
